// File: rtl/tape_pkg.sv
// Shared constants and state encoding for the tape packet line decoder and encoder.
package tape_pkg;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    localparam int XY_F = 6;
    localparam int XY_V = 5;
    localparam int XY_H = 4;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN,
        PAY,
        CHK,
        DROP
    } state_t;

endpackage

// File: rtl/tape_byte_fifo.sv
// Byte FIFO with a registered head stage; push and pop in the same cycle are both honoured.
module tape_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   mem_cnt;
    logic [AW:0]   total;
    logic          do_pop, do_push, load;

    // Occupancy counts the head register as well as the memory behind it.
    assign total   = mem_cnt + (AW+1)'(out_valid);
    assign full    = (total == (AW+1)'(DEPTH));
    assign do_pop  = pop && out_valid;
    assign do_push = push && (!full || do_pop);
    assign load    = (mem_cnt != '0) && (!out_valid || do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (load) begin
                out_data  <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                out_valid <= 1'b1;
            end else if (do_pop) begin
                out_valid <= 1'b0;
            end
            unique case ({do_push, load})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

endmodule

// File: rtl/tape_line_decoder.sv
// Recovers one tape packet per active BT.656 line: slices luma into bits, frames bytes, checks the packet.
module tape_line_decoder
    import tape_pkg::*;
#(
    parameter int         SPS        = 4,
    parameter logic [7:0] THRESHOLD  = 8'd128,
    parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] td_data,
    input  logic       en,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       pkt_good,
    output logic       pkt_bad,
    output logic [7:0] pkt_len,
    output logic       overflow,
    output logic       line_active
);

    localparam int LW = $clog2(SPS);

    logic [7:0]    hist0, hist1, hist2;
    logic          trs, sav, eav, start, sym;
    logic [10:0]   samp_idx;
    logic [LW-1:0] luma_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    byte_p0;
    logic          vld_p0;
    state_t        state, state_nxt;
    logic [7:0]    len, csum, pay_cnt;
    logic          drop_seen, push, good_nxt, bad_nxt, fifo_full, pop;

    assign trs   = (hist2 == TRS_FF) && (hist1 == TRS_00) && (hist0 == TRS_00);
    assign sav   = trs && !td_data[XY_H];
    assign eav   = trs && td_data[XY_H];
    assign start = (state == IDLE) && sav && en && !td_data[XY_V];
    assign sym   = (td_data >= THRESHOLD);
    assign pop   = out_valid && out_ready;

    // Stage p0: sample phasing, symbol slicing and byte assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist0    <= '0;
            hist1    <= '0;
            hist2    <= '0;
            samp_idx <= '0;
            luma_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            byte_p0  <= '0;
            vld_p0   <= 1'b0;
        end else begin
            hist2  <= hist1;
            hist1  <= hist0;
            hist0  <= td_data;
            vld_p0 <= 1'b0;
            if (start || eav) begin
                samp_idx <= '0;
                luma_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= '0;
            end else if (line_active && !trs) begin
                if (samp_idx != 11'd2047)
                    samp_idx <= samp_idx + 1'b1;
                if (samp_idx[0]) begin
                    luma_cnt <= (luma_cnt == LW'(SPS-1)) ? '0 : luma_cnt + 1'b1;
                    if (luma_cnt == LW'(SPS/2)) begin
                        shreg   <= {shreg[6:0], sym};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            byte_p0 <= {shreg[6:0], sym};
                            vld_p0  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = 1'b0;
        bad_nxt   = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = SYNC;
            SYNC: if (vld_p0) state_nxt = (byte_p0 == SYNC_BYTE) ? LEN : DROP;
            LEN:  if (vld_p0) state_nxt = (byte_p0 == 8'd0) ? CHK : PAY;
            PAY: begin
                if (vld_p0) begin
                    push = 1'b1;
                    if (8'(pay_cnt + 8'd1) == len)
                        state_nxt = CHK;
                end
            end
            CHK: begin
                if (vld_p0) begin
                    good_nxt  = (byte_p0 == csum) && !drop_seen;
                    bad_nxt   = !good_nxt;
                    state_nxt = DROP;
                end
            end
            DROP: state_nxt = DROP;
            default: state_nxt = IDLE;
        endcase
        // End of line wins over any byte landing in the same cycle.
        if (eav) begin
            state_nxt = IDLE;
            push      = 1'b0;
            good_nxt  = 1'b0;
            bad_nxt   = (state == LEN) || (state == PAY) || (state == CHK);
        end
    end

    // Stage p1: packet bookkeeping and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len         <= '0;
            csum        <= '0;
            pay_cnt     <= '0;
            drop_seen   <= 1'b0;
            pkt_good    <= 1'b0;
            pkt_bad     <= 1'b0;
            pkt_len     <= '0;
            overflow    <= 1'b0;
            line_active <= 1'b0;
        end else begin
            pkt_good <= good_nxt;
            pkt_bad  <= bad_nxt;
            if (start)
                line_active <= 1'b1;
            else if (eav)
                line_active <= 1'b0;
            if (state == LEN && vld_p0 && !eav) begin
                len       <= byte_p0;
                csum      <= '0;
                pay_cnt   <= '0;
                drop_seen <= 1'b0;
            end
            if (push) begin
                csum    <= csum + byte_p0;
                pay_cnt <= pay_cnt + 1'b1;
                if (fifo_full && !pop) begin
                    overflow  <= 1'b1;
                    drop_seen <= 1'b1;
                end
            end
            if (good_nxt || bad_nxt)
                pkt_len <= (state == LEN) ? 8'd0 : len;
        end
    end

    tape_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(byte_p0),
        .pop      (out_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_tape_line_decoder.sv
// Directed bench for tape_line_decoder: BT.656 lines carrying tape packets, with a pop/pulse monitor.
module tb_tape_line_decoder;
    import tape_pkg::*;

    localparam int SPS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] td_data;
    logic       en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       pkt_good;
    logic       pkt_bad;
    logic [7:0] pkt_len;
    logic       overflow;
    logic       line_active;

    int n_checks = 0;
    int n_fail   = 0;
    int n_good   = 0;
    int n_bad    = 0;
    logic [7:0] rx [$];

    always #5 clk = ~clk;

    tape_line_decoder #(
        .SPS       (SPS),
        .THRESHOLD (8'd128),
        .SYNC_BYTE (8'hA5),
        .FIFO_DEPTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .td_data    (td_data),
        .en         (en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pkt_good   (pkt_good),
        .pkt_bad    (pkt_bad),
        .pkt_len    (pkt_len),
        .overflow   (overflow),
        .line_active(line_active)
    );

    // Records every accepted byte and every status pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready)
                rx.push_back(out_data);
            if (pkt_good)
                n_good++;
            if (pkt_bad)
                n_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [7:0] v);
        td_data = v;
        @(posedge clk);
        #1;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++)
            tick(8'h10);
    endtask

    task automatic send_sav();
        tick(8'hFF); tick(8'h00); tick(8'h00); tick(8'h80);
    endtask

    task automatic send_eav();
        tick(8'hFF); tick(8'h00); tick(8'h00); tick(8'h90);
    endtask

    task automatic send_sym(input logic b);
        for (int j = 0; j < SPS; j++) begin
            tick(8'h80);
            tick(b ? 8'hEB : 8'h10);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            send_sym(v[i]);
    endtask

    int rx_base, g0, b0;
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [2];

    initial begin
        rst = 1'b1; en = 1'b1; out_ready = 1'b1; td_data = 8'h10;
        exp_a = '{8'h11, 8'h22, 8'h33};
        exp_b = '{8'h01, 8'h02};
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_pkt_good", 32'(pkt_good), 32'd0);
        check("rst_pkt_bad", 32'(pkt_bad), 32'd0);
        check("rst_pkt_len", 32'(pkt_len), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_line_active", 32'(line_active), 32'd0);
        rst = 1'b0;
        blank(8);

        // Good packet: A5 03 11 22 33 66
        rx_base = rx.size(); g0 = n_good; b0 = n_bad;
        send_sav();
        check("t1_line_active_hi", 32'(line_active), 32'd1);
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h66);
        blank(8);
        send_eav();
        check("t1_line_active_lo", 32'(line_active), 32'd0);
        blank(8);
        check("t1_rx_count", 32'(rx.size() - rx_base), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t1_rx%0d", i), 32'(rx[rx_base+i]), 32'(exp_a[i]));
        check("t1_good", 32'(n_good - g0), 32'd1);
        check("t1_bad", 32'(n_bad - b0), 32'd0);
        check("t1_pkt_len", 32'(pkt_len), 32'd3);
        check("t1_overflow", 32'(overflow), 32'd0);

        // Bad checksum: 67 instead of 66
        rx_base = rx.size(); g0 = n_good; b0 = n_bad;
        send_sav();
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h67);
        blank(8);
        send_eav();
        blank(8);
        check("t2_rx_count", 32'(rx.size() - rx_base), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t2_rx%0d", i), 32'(rx[rx_base+i]), 32'(exp_a[i]));
        check("t2_good", 32'(n_good - g0), 32'd0);
        check("t2_bad", 32'(n_bad - b0), 32'd1);
        check("t2_pkt_len", 32'(pkt_len), 32'd3);

        // Wrong sync byte: line dropped silently
        rx_base = rx.size(); g0 = n_good; b0 = n_bad;
        send_sav();
        send_byte(8'h5A); send_byte(8'h03); send_byte(8'h11);
        blank(8);
        check("t3_line_active_hi", 32'(line_active), 32'd1);
        send_eav();
        check("t3_line_active_lo", 32'(line_active), 32'd0);
        blank(8);
        check("t3_rx_count", 32'(rx.size() - rx_base), 32'd0);
        check("t3_good", 32'(n_good - g0), 32'd0);
        check("t3_bad", 32'(n_bad - b0), 32'd0);

        // Truncated packet: len 5, only two payload bytes before EAV
        rx_base = rx.size(); g0 = n_good; b0 = n_bad;
        send_sav();
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
        send_eav();
        check("t4_pkt_bad_pulse", 32'(pkt_bad), 32'd1);
        check("t4_pkt_len", 32'(pkt_len), 32'd5);
        check("t4_state_idle", 32'(dut.state), 32'(IDLE));
        check("t4_line_active", 32'(line_active), 32'd0);
        blank(8);
        check("t4_rx_count", 32'(rx.size() - rx_base), 32'd2);
        for (int i = 0; i < 2; i++)
            check($sformatf("t4_rx%0d", i), 32'(rx[rx_base+i]), 32'(exp_b[i]));
        check("t4_bad", 32'(n_bad - b0), 32'd1);
        check("t4_good", 32'(n_good - g0), 32'd0);

        // Decoder disabled: SAV ignored
        en = 1'b0;
        send_sav();
        blank(16);
        check("t5_disabled_line", 32'(line_active), 32'd0);
        send_eav();
        en = 1'b1;
        blank(4);

        // Overflow: 20-byte payload into a 16-entry FIFO with no consumer
        out_ready = 1'b0;
        g0 = n_good; b0 = n_bad;
        send_sav();
        send_byte(8'hA5); send_byte(8'd20);
        for (int i = 1; i <= 20; i++)
            send_byte(8'(i));
        send_byte(8'hD2);
        blank(8);
        send_eav();
        blank(8);
        check("t6_overflow", 32'(overflow), 32'd1);
        check("t6_out_valid", 32'(out_valid), 32'd1);
        check("t6_head", 32'(out_data), 32'd1);
        check("t6_bad", 32'(n_bad - b0), 32'd1);
        check("t6_good", 32'(n_good - g0), 32'd0);
        check("t6_pkt_len", 32'(pkt_len), 32'd20);
        rx_base = rx.size();
        out_ready = 1'b1;
        blank(40);
        check("t6_drain_count", 32'(rx.size() - rx_base), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t6_drain%0d", i), 32'(rx[rx_base+i]), 32'(i + 1));
        check("t6_empty", 32'(out_valid), 32'd0);
        check("t6_overflow_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of the payload, then a clean line
        send_sav();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_sym(1'b0); send_sym(1'b0); send_sym(1'b1);
        rst = 1'b1;
        #1;
        check("t7_out_valid", 32'(out_valid), 32'd0);
        check("t7_out_data", 32'(out_data), 32'd0);
        check("t7_pkt_len", 32'(pkt_len), 32'd0);
        check("t7_overflow", 32'(overflow), 32'd0);
        check("t7_line_active", 32'(line_active), 32'd0);
        check("t7_pkt_flags", 32'({pkt_good, pkt_bad}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        blank(8);
        rx_base = rx.size(); g0 = n_good; b0 = n_bad;
        send_sav();
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h66);
        blank(8);
        send_eav();
        blank(8);
        check("t7_rx_count", 32'(rx.size() - rx_base), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t7_rx%0d", i), 32'(rx[rx_base+i]), 32'(exp_a[i]));
        check("t7_good", 32'(n_good - g0), 32'd1);
        check("t7_bad", 32'(n_bad - b0), 32'd0);
        check("t7_len_after", 32'(pkt_len), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
